// File: rtl/audio_tone_sequencer_pkg.sv
// Shared types and constants for the tone sequencer slice.
package audio_pkg;

  localparam int unsigned INDEX_W            = 8;
  localparam int unsigned SAMPLE_W           = 8;
  localparam int unsigned DEFAULT_SAMPLE_DIV = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/audio_tone_sequencer_tick.sv
// Periodic sample-tick generator; counter parks at 0 while disabled so the
// first enabled cycle ticks immediately.
module sample_tick_gen
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = DEFAULT_SAMPLE_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_DIV);

  logic [CNT_W-1:0] cnt;

  assign tick = enable && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= CNT_W'(SAMPLE_DIV - 1);
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/audio_tone_sequencer.sv
// Plays one note: phase accumulator addresses an external waveform table,
// samples are handed to a valid/ready sink, and a length counter ends the note.
module audio_tone_sequencer
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = DEFAULT_SAMPLE_DIV,
  parameter int unsigned PHASE_W    = 16,
  parameter int unsigned LEN_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic [PHASE_W-1:0]  tune_word,
  input  logic [LEN_W-1:0]    note_len,
  output logic [INDEX_W-1:0]  index,
  input  logic [SAMPLE_W-1:0] table_data,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                busy,
  output logic                done,
  output logic                overrun
);

  state_t             state;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] tune_q;
  logic [LEN_W-1:0]   remaining;
  logic               run_en;
  logic               tick;
  logic               handshake;

  assign run_en    = (state == RUN);
  assign handshake = sample_valid && sample_ready;
  assign index     = phase[PHASE_W-1 -: INDEX_W];
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  sample_tick_gen #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (run_en),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      phase        <= '0;
      tune_q       <= '0;
      remaining    <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            tune_q       <= tune_word;
            remaining    <= note_len;
            phase        <= '0;
            overrun      <= 1'b0;
            sample_valid <= 1'b0;
            state        <= (note_len == '0) ? DONE : RUN;
          end else if (handshake) begin
            sample_valid <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            // Abort drops any capture this cycle and freezes the phase.
            state        <= IDLE;
            sample_valid <= 1'b0;
          end else begin
            if (tick) begin
              sample_out   <= table_data;
              sample_valid <= 1'b1;
              phase        <= phase + tune_q;
              remaining    <= remaining - 1'b1;
              if (sample_valid && !sample_ready) overrun <= 1'b1;
            end else if (handshake) begin
              sample_valid <= 1'b0;
            end
            // Final tick has already emptied the counter; SAMPLE_DIV>=2 keeps
            // this cycle tick-free.
            if (remaining == '0) state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          if (handshake) sample_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_tone_sequencer.sv
// Directed self-checking bench for audio_tone_sequencer with an XOR table stub.
module tb_audio_tone_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] tune_word = '0;
  logic [15:0] note_len = '0;
  logic [7:0]  index;
  logic [7:0]  table_data;
  logic [7:0]  sample_out;
  logic        sample_valid;
  logic        sample_ready = 1'b1;
  logic        busy;
  logic        done;
  logic        overrun;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign table_data = index ^ 8'hA5;

  audio_tone_sequencer #(
    .SAMPLE_DIV(4),
    .PHASE_W(16),
    .LEN_W(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .tune_word    (tune_word),
    .note_len     (note_len),
    .index        (index),
    .table_data   (table_data),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [15:0] tw, input logic [15:0] len);
    start = 1'b1; tune_word = tw; note_len = len;
    step(1);
    start = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    if ({busy, done, sample_valid, overrun, index, sample_out} !== 20'h0) begin
      $display("FAIL reset_outputs: got %h want 0", {busy, done, sample_valid, overrun, index, sample_out}); n_err++;
    end
    n_cmp++;
    step(2);
    rst_n = 1'b1;
    step(1);
    if (busy !== 1'b0) begin $display("FAIL reset_idle_busy: got %b want 0", busy); n_err++; end
    n_cmp++;
  endtask

  task automatic test_basic_note;
    sample_ready = 1'b1;
    do_start(16'h0100, 16'd3);
    if (busy !== 1'b1) begin $display("FAIL basic_busy_k: got %b want 1", busy); n_err++; end
    n_cmp++;
    if (sample_valid !== 1'b0) begin $display("FAIL basic_valid_k: got %b want 0", sample_valid); n_err++; end
    n_cmp++;
    step(1);
    if (sample_valid !== 1'b1 || sample_out !== 8'hA5) begin
      $display("FAIL basic_s0: got v=%b d=%h want v=1 d=a5", sample_valid, sample_out); n_err++;
    end
    n_cmp++;
    step(1);
    if (sample_valid !== 1'b0) begin $display("FAIL basic_consumed: got %b want 0", sample_valid); n_err++; end
    n_cmp++;
    step(3);
    if (sample_valid !== 1'b1 || sample_out !== 8'hA4) begin
      $display("FAIL basic_s1: got v=%b d=%h want v=1 d=a4", sample_valid, sample_out); n_err++;
    end
    n_cmp++;
    step(4);
    if (sample_out !== 8'hA7 || done !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL basic_s2: got d=%h done=%b busy=%b want d=a7 done=0 busy=1", sample_out, done, busy); n_err++;
    end
    n_cmp++;
    step(1);
    if (done !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0) begin
      $display("FAIL basic_done: got done=%b busy=%b ovr=%b want 1 0 0", done, busy, overrun); n_err++;
    end
    n_cmp++;
    step(1);
    if (done !== 1'b0) begin $display("FAIL basic_done_pulse: got %b want 0", done); n_err++; end
    n_cmp++;
  endtask

  task automatic test_wrap;
    do_start(16'h8000, 16'd4);
    step(1);
    if (sample_out !== 8'hA5 || index !== 8'h80) begin
      $display("FAIL wrap_s0: got d=%h idx=%h want a5 80", sample_out, index); n_err++;
    end
    n_cmp++;
    step(4);
    if (sample_out !== 8'h25 || index !== 8'h00) begin
      $display("FAIL wrap_s1: got d=%h idx=%h want 25 00", sample_out, index); n_err++;
    end
    n_cmp++;
    step(4);
    if (sample_out !== 8'hA5) begin $display("FAIL wrap_s2: got %h want a5", sample_out); n_err++; end
    n_cmp++;
    step(4);
    if (sample_out !== 8'h25) begin $display("FAIL wrap_s3: got %h want 25", sample_out); n_err++; end
    n_cmp++;
    step(1);
    if (done !== 1'b1) begin $display("FAIL wrap_done: got %b want 1", done); n_err++; end
    n_cmp++;
    step(1);
  endtask

  task automatic test_backpressure;
    sample_ready = 1'b0;
    do_start(16'h0100, 16'd2);
    step(1);
    if (sample_out !== 8'hA5 || overrun !== 1'b0) begin
      $display("FAIL bp_s0: got d=%h ovr=%b want a5 0", sample_out, overrun); n_err++;
    end
    n_cmp++;
    step(4);
    if (sample_out !== 8'hA4 || overrun !== 1'b1 || sample_valid !== 1'b1) begin
      $display("FAIL bp_overwrite: got d=%h ovr=%b v=%b want a4 1 1", sample_out, overrun, sample_valid); n_err++;
    end
    n_cmp++;
    step(2);
    if (sample_valid !== 1'b1 || overrun !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL bp_idle_hold: got v=%b ovr=%b busy=%b want 1 1 0", sample_valid, overrun, busy); n_err++;
    end
    n_cmp++;
    sample_ready = 1'b1;
    do_start(16'h0100, 16'd1);
    if (overrun !== 1'b0 || sample_valid !== 1'b0) begin
      $display("FAIL bp_clear: got ovr=%b v=%b want 0 0", overrun, sample_valid); n_err++;
    end
    n_cmp++;
    step(3);
  endtask

  task automatic test_stop;
    int saw_done;
    saw_done = 0;
    do_start(16'h0100, 16'd10);
    step(6);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    if (busy !== 1'b0 || sample_valid !== 1'b0 || done !== 1'b0) begin
      $display("FAIL stop_idle: got busy=%b v=%b done=%b want 0 0 0", busy, sample_valid, done); n_err++;
    end
    n_cmp++;
    if (index !== 8'h02) begin $display("FAIL stop_phase_held: got %h want 02", index); n_err++; end
    n_cmp++;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1 || busy === 1'b1) saw_done = 1;
      step(1);
    end
    if (saw_done !== 0) begin $display("FAIL stop_no_done: got %0d want 0", saw_done); n_err++; end
    n_cmp++;
  endtask

  task automatic test_zero_len;
    do_start(16'h0100, 16'd0);
    if (done !== 1'b1 || busy !== 1'b0 || sample_valid !== 1'b0) begin
      $display("FAIL zero_done: got done=%b busy=%b v=%b want 1 0 0", done, busy, sample_valid); n_err++;
    end
    n_cmp++;
    step(1);
    if (done !== 1'b0 || sample_valid !== 1'b0) begin
      $display("FAIL zero_after: got done=%b v=%b want 0 0", done, sample_valid); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_start_stop_together;
    start = 1'b1; stop = 1'b1; note_len = 16'd2; tune_word = 16'h0100;
    step(1);
    start = 1'b0; stop = 1'b0;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL startstop_idle: got busy=%b done=%b want 0 0", busy, done); n_err++;
    end
    n_cmp++;
    step(1);
    if (busy !== 1'b0 || sample_valid !== 1'b0) begin
      $display("FAIL startstop_hold: got busy=%b v=%b want 0 0", busy, sample_valid); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_back_to_back;
    do_start(16'h0100, 16'd3);
    step(2);
    start = 1'b1; tune_word = 16'h4000; note_len = 16'd1;
    step(1);
    start = 1'b0;
    step(2);
    if (sample_out !== 8'hA4 || index !== 8'h02) begin
      $display("FAIL b2b_tune_kept: got d=%h idx=%h want a4 02", sample_out, index); n_err++;
    end
    n_cmp++;
    step(4);
    if (sample_out !== 8'hA7 || done !== 1'b0) begin
      $display("FAIL b2b_len_kept: got d=%h done=%b want a7 0", sample_out, done); n_err++;
    end
    n_cmp++;
    step(1);
    if (done !== 1'b1) begin $display("FAIL b2b_done: got %b want 1", done); n_err++; end
    n_cmp++;
    step(1);
  endtask

  task automatic test_async_reset;
    do_start(16'h0100, 16'd5);
    step(6);
    if (busy !== 1'b1 || sample_out !== 8'hA4) begin
      $display("FAIL areset_pre: got busy=%b d=%h want 1 a4", busy, sample_out); n_err++;
    end
    n_cmp++;
    #2;
    rst_n = 1'b0;
    #1;
    if ({busy, done, sample_valid, overrun, index, sample_out} !== 20'h0) begin
      $display("FAIL areset_immediate: got %h want 0", {busy, done, sample_valid, overrun, index, sample_out}); n_err++;
    end
    n_cmp++;
    #3;
    rst_n = 1'b1;
    step(1);
    do_start(16'h0100, 16'd1);
    if (busy !== 1'b1) begin $display("FAIL areset_restart_busy: got %b want 1", busy); n_err++; end
    n_cmp++;
    step(1);
    if (sample_valid !== 1'b1 || sample_out !== 8'hA5) begin
      $display("FAIL areset_restart_s0: got v=%b d=%h want 1 a5", sample_valid, sample_out); n_err++;
    end
    n_cmp++;
    step(1);
    if (done !== 1'b1) begin $display("FAIL areset_restart_done: got %b want 1", done); n_err++; end
    n_cmp++;
    step(1);
  endtask

  initial begin
    test_reset();
    test_basic_note();
    test_wrap();
    test_backpressure();
    test_stop();
    test_zero_len();
    test_start_stop_together();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/audio_tone_sequencer.md
Name: audio_tone_sequencer

Overview:
Drives the 8-bit waveform lookup `buildAudioSignal` (`index` in, `filledOutput` out; purely combinational) to play one note.
- A phase accumulator steps the table index at a programmable rate (`tune_word`) on a periodic sample tick.
- Each table output is captured into a registered sample with a valid/ready handshake to the downstream audio sink.
- A note-length counter ends playback and pulses `done`.

Parameters:
- SAMPLE_DIV, 4, clock cycles per sample tick (>=2).
- PHASE_W, 16, phase accumulator width (>=8); table index is `phase[PHASE_W-1 -: 8]`.
- LEN_W, 16, width of `note_len` and the remaining-sample counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a note; honoured only in IDLE.
- stop  in  1  abort playback; honoured in RUN.
- tune_word  in  PHASE_W  phase increment per sample; latched on accepted start.
- note_len  in  LEN_W  number of samples to emit; latched on accepted start.
- index  out  8  address to `buildAudioSignal`; equals `phase[PHASE_W-1 -: 8]`.
- table_data  in  8  `filledOutput` of `buildAudioSignal`.
- sample_out  out  8  registered sample.
- sample_valid  out  1  `sample_out` holds an unconsumed sample.
- sample_ready  in  1  sink accepts the sample when valid&&ready at a clock edge.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at normal note completion.
- overrun  out  1  sticky; set when an unconsumed sample is overwritten; cleared on accepted start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, phase=0, remaining=0, tick counter=0, index=0, sample_out=0, sample_valid=0, busy=0, done=0, overrun=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and stop=0 at edge k → RUN from edge k.
  - Latch tune_word and note_len; phase=0; tick counter=0; overrun=0; sample_valid=0.
  - start=1 with stop=1 → stay IDLE.
  - note_len=0 → go directly to DONE instead of RUN.
- RUN:
  - Tick counter: tick when the counter is 0, then reload SAMPLE_DIV-1; otherwise decrement.
  - The first tick is in the first RUN cycle, so the first sample is valid after edge k+1. Later samples follow every SAMPLE_DIV clocks.
  - On a tick: sample_out ← table_data (at the current index); sample_valid ← 1; phase ← phase + tune_word (mod 2^PHASE_W, wraps silently); remaining ← remaining − 1.
  - If sample_valid=1 and sample_ready=0 at a tick: the new sample overwrites and overrun ← 1.
  - If a tick coincides with a handshake: the new sample is loaded and valid stays 1, with no overrun.
  - A handshake without a tick clears sample_valid.
  - The tick that makes remaining 0 → DONE on the next edge.
  - stop=1 in RUN (including on a tick cycle) → IDLE next edge. sample_valid cleared, no done pulse, the tick's capture is discarded, phase is held.
- DONE: done=1 for exactly one cycle, then IDLE. The last sample stays valid until handshaken; it may still be consumed in IDLE.
- start while in RUN or DONE is ignored.
- busy = (state==RUN).
- index is registered from phase, so table_data settles within the same cycle the index is presented. No extra pipeline stage.
- Reset assertion mid-note returns all state to reset values immediately, with no done pulse.

Decomposition:
- Package `audio_pkg`:
  - state enum (IDLE, RUN, DONE);
  - localparams INDEX_W=8, SAMPLE_W=8;
  - default SAMPLE_DIV.
- Sub-module `sample_tick_gen` (parameter SAMPLE_DIV; ports clk, rst_n, enable, tick). The counter is held at 0 while enable=0, so the first enabled cycle ticks.
- The `buildAudioSignal` instance stays outside this block.

Test Plan:
- Bench defaults: SAMPLE_DIV=4, table stub driving `table_data = index ^ 8'hA5`, sample_ready=1.
- Basic note: tune_word=16'h0100, note_len=3, start pulse → samples 0xA5, 0xA4, 0xA7 at edges k+1, k+5, k+9; done pulse one cycle after the third sample; busy high from k to DONE; overrun=0.
- Wrap: tune_word=16'h8000, note_len=4 → indices 0, 128, 0, 128; samples 0xA5, 0x25, 0xA5, 0x25; phase wraps with no error.
- Backpressure: sample_ready=0 throughout, tune_word=16'h0100, note_len=2 → second tick overwrites, sample_out=0xA4, overrun=1; overrun clears on the next accepted start.
- Stop mid-note: note_len=10, stop asserted on cycle 6 → IDLE next edge, sample_valid=0, done never pulses, busy=0.
- Edge cases:
  - note_len=0 → done pulse on the cycle after start, no sample_valid.
  - start+stop together in IDLE → remains IDLE.
  - start during RUN → ignored; the latched tune_word is unchanged.
- Async reset: drop rst_n mid-RUN between clock edges → all outputs are 0 immediately (before the next clk edge); after release, a new start plays normally.
